reset_sequencer: RTL and testbench

Parametrised single-clock reset generator: asynchronously asserts NUM_CH active-high reset outputs, synchronously releases them after a hold period, one channel at a time with a fixed gap, then flags completion. Accepts a synchronous soft-reset request that restarts the whole sequence without a board reset. Sits at the root of each clock domain, downstream of any cross-domain reset transport, and drives per-subsystem `rst` inputs in a defined bring-up order.

---
 rtl/reset_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer
//   Root reset generator for one clock domain. All reset outputs assert
//   asynchronously with rst_n. After a synchronised release they stay high for
//   HOLD_CYCLES, then drop one channel at a time, GAP_CYCLES apart and
//   channel 0 first. done is flagged once every channel has been released. A
//   single-cycle soft_rst_req restarts the whole sequence without a board reset.
//
// Parameters
//   NUM_CH       number of reset channels (>=1)
//   SYNC_STAGES  depth of the rst_n release synchroniser (>=2)
//   HOLD_CYCLES  cycles all channels stay asserted before channel 0 drops (>=1)
//   GAP_CYCLES   cycles between consecutive channel releases (>=1)
//
// Ports
//   clk           sole clock
//   rst_n         asynchronous active-low reset
//   soft_rst_req  synchronous active-high restart request
//   ch_ready      per-channel ready (only with RESET_SEQ_ACK_EN)
//   rst_out       active-high reset, one bit per channel
//   busy          sequence still in progress
//   done          sequence complete
//
// Optional feature macro: RESET_SEQ_ACK_EN
//   When defined, the next channel is released only once the previously
//   released channel reports ch_ready. done then waits for the last channel's
//   ready as well.
module reset_sequencer #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              soft_rst_req,
`ifdef RESET_SEQ_ACK_EN
  input  logic [NUM_CH-1:0] ch_ready,
`endif
  output logic [NUM_CH-1:0] rst_out,
  output logic              busy,
  output logic              done
);

  localparam int MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int IDX_W   = $clog2(NUM_CH + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_RELEASE   = 2'd1,
`ifdef RESET_SEQ_ACK_EN
    ST_WAIT_LAST = 2'd2,
`endif
    ST_RUN       = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_CH-1:0]      rst_out_q, rst_out_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   rst_sync_n_s;
  logic                   release_go_s;

  // One-hot select of a channel; indices at or beyond NUM_CH select nothing.
  function automatic logic [NUM_CH-1:0] chan_mask(input logic [IDX_W-1:0] ch);
    logic [NUM_CH-1:0] m;
    m = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      m[i] = (i == int'(ch));
    end
    return m;
  endfunction

`ifdef RESET_SEQ_ACK_EN
  // Ready bit of the channel most recently released.
  function automatic logic ready_sel(input logic [NUM_CH-1:0] rdy,
                                     input logic [IDX_W-1:0]  ch);
    logic r;
    r = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      r = r | (rdy[i] & (i == int'(ch)));
    end
    return r;
  endfunction
`endif

  assign rst_sync_n_s = sync_q[SYNC_STAGES-1];

  // Release synchroniser: shifts in a constant 1 behind the async clear.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  // Next-state and output logic of the sequencing FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    busy_d    = busy_q;
    done_d    = done_q;
`ifdef RESET_SEQ_ACK_EN
    // Gap elapsed and the previously released channel has come up.
    release_go_s = (cnt_q >= GAP_LAST) && ready_sel(ch_ready, idx_q);
`else
    release_go_s = (cnt_q == GAP_LAST);
`endif

    if (!rst_sync_n_s) begin
      // Still inside the synchroniser window: FSM frozen, soft requests ignored.
      state_d = state_q;
    end else if (soft_rst_req) begin
      // Restart outranks any release or completion on the same edge.
      state_d   = ST_HOLD;
      cnt_d     = {CNT_W{1'b0}};
      idx_d     = {IDX_W{1'b0}};
      rst_out_d = {NUM_CH{1'b1}};
      busy_d    = 1'b1;
      done_d    = 1'b0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            rst_out_d[0] = 1'b0;
            cnt_d        = {CNT_W{1'b0}};
            idx_d        = {IDX_W{1'b0}};
            if (NUM_CH == 1) begin
`ifdef RESET_SEQ_ACK_EN
              state_d = ST_WAIT_LAST;
`else
              state_d = ST_RUN;
              busy_d  = 1'b0;
              done_d  = 1'b1;
`endif
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_RELEASE: begin
          if (release_go_s) begin
            rst_out_d = rst_out_q & ~chan_mask(idx_q + IDX_ONE);
            idx_d     = idx_q + IDX_ONE;
            cnt_d     = {CNT_W{1'b0}};
            if ((idx_q + IDX_ONE) == LAST_IDX) begin
`ifdef RESET_SEQ_ACK_EN
              state_d = ST_WAIT_LAST;
`else
              state_d = ST_RUN;
              busy_d  = 1'b0;
              done_d  = 1'b1;
`endif
            end else begin
              state_d = ST_RELEASE;
            end
          end else begin
            // Counter saturates at the gap limit while a release is held off.
            cnt_d = (cnt_q >= GAP_LAST) ? cnt_q : (cnt_q + CNT_ONE);
          end
        end
`ifdef RESET_SEQ_ACK_EN
        ST_WAIT_LAST: begin
          if (ch_ready[NUM_CH-1]) begin
            state_d = ST_RUN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WAIT_LAST;
          end
        end
`endif
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          // Unreachable encoding: fall back to a full restart.
          state_d   = ST_HOLD;
          cnt_d     = {CNT_W{1'b0}};
          idx_d     = {IDX_W{1'b0}};
          rst_out_d = {NUM_CH{1'b1}};
          busy_d    = 1'b1;
          done_d    = 1'b0;
        end
      endcase
    end
  end

  // State, counters, synchroniser and registered outputs; rst_n asserts async.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= {SYNC_STAGES{1'b0}};
      state_q   <= ST_HOLD;
      cnt_q     <= {CNT_W{1'b0}};
      idx_q     <= {IDX_W{1'b0}};
      rst_out_q <= {NUM_CH{1'b1}};
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign rst_out = rst_out_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
//   Bench for reset_sequencer: a default 4-channel instance and a 1-channel
//   instance (HOLD_CYCLES=1, GAP_CYCLES=1) share clock, rst_n and soft_rst_req.
//   Expected outputs come from a timing model: channel i drops after edge
//   ref+HOLD+i*GAP, where ref is the synchroniser depth after rst_n release or
//   the edge at which an accepted soft request was sampled.
module tb_reset_sequencer;

  localparam int NUM_CH = 4;
  localparam int SYNC   = 2;
  localparam int HOLD   = 16;
  localparam int GAP    = 4;
`ifdef RESET_SEQ_ACK_EN
  localparam int ACK_EXTRA = 1;
`else
  localparam int ACK_EXTRA = 0;
`endif

  logic              clk          = 1'b0;
  logic              rst_n        = 1'b1;
  logic              soft_rst_req = 1'b0;
  logic [NUM_CH-1:0] rst_out;
  logic              busy;
  logic              done;
  logic [0:0]        rst_out1;
  logic              busy1;
  logic              done1;
`ifdef RESET_SEQ_ACK_EN
  logic [NUM_CH-1:0] ch_ready = {NUM_CH{1'b1}};
`endif

  int         n_checks = 0;
  int         n_err    = 0;
  int         edge_n   = 0;
  int         ref_e    = 0;
  logic [9:0] exp_v;
  logic [9:0] exp1_v;

  always #5 clk = ~clk;

  reset_sequencer #(.NUM_CH(NUM_CH), .SYNC_STAGES(SYNC),
                    .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .soft_rst_req (soft_rst_req),
`ifdef RESET_SEQ_ACK_EN
    .ch_ready     (ch_ready),
`endif
    .rst_out      (rst_out),
    .busy         (busy),
    .done         (done)
  );

  reset_sequencer #(.NUM_CH(1), .SYNC_STAGES(SYNC),
                    .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .soft_rst_req (soft_rst_req),
`ifdef RESET_SEQ_ACK_EN
    .ch_ready     (1'b1),
`endif
    .rst_out      (rst_out1),
    .busy         (busy1),
    .done         (done1)
  );

  // Reference: bits [7:0] rst_out, [8] busy, [9] done.
  function automatic logic [9:0] model(input logic rn, input int k, input int r,
                                       input int n, input int h, input int g);
    logic [9:0] v;
    v = 10'b0;
    if (!rn) begin
      for (int i = 0; i < n; i++) v[i] = 1'b1;
      v[8] = 1'b1;
    end else begin
      for (int i = 0; i < n; i++) v[i] = (k < r + h + i * g);
      v[9] = (k >= r + h + (n - 1) * g + ACK_EXTRA);
      v[8] = ~v[9];
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst_n) edge_n++;
    #1;
  endtask

  task automatic assert_rst();
    rst_n  = 1'b0;
    edge_n = 0;
  endtask

  task automatic release_rst();
    rst_n  = 1'b1;
    edge_n = 0;
    ref_e  = SYNC;
  endtask

  // One-cycle soft request; only accepted once the synchroniser has released.
  task automatic pulse_soft();
    soft_rst_req = 1'b1;
    tick();
    if (rst_n && edge_n > SYNC) ref_e = edge_n;
    soft_rst_req = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    assert_rst();
    #1;
    exp_v = model(rst_n, edge_n, ref_e, NUM_CH, HOLD, GAP);
    n_checks++;
    if ({done, busy, rst_out} !== {exp_v[9], exp_v[8], exp_v[NUM_CH-1:0]}) begin
      n_err++;
      $display("FAIL reset_async got rst=%b busy=%b done=%b exp rst=%b busy=%b done=%b",
               rst_out, busy, done, exp_v[NUM_CH-1:0], exp_v[8], exp_v[9]);
    end
    repeat (5) begin
      tick();
      exp_v = model(rst_n, edge_n, ref_e, NUM_CH, HOLD, GAP);
      n_checks++;
      if ({done, busy, rst_out} !== {exp_v[9], exp_v[8], exp_v[NUM_CH-1:0]}) begin
        n_err++;
        $display("FAIL reset_hold got rst=%b busy=%b done=%b exp rst=%b busy=%b done=%b",
                 rst_out, busy, done, exp_v[NUM_CH-1:0], exp_v[8], exp_v[9]);
      end
    end
  endtask

  task automatic test_power_up();
    release_rst();
    repeat (35) begin
      tick();
      exp_v = model(rst_n, edge_n, ref_e, NUM_CH, HOLD, GAP);
      n_checks++;
      if ({done, busy, rst_out} !== {exp_v[9], exp_v[8], exp_v[NUM_CH-1:0]}) begin
        n_err++;
        $display("FAIL power_up edge=%0d got rst=%b busy=%b done=%b exp rst=%b busy=%b done=%b",
                 edge_n, rst_out, busy, done, exp_v[NUM_CH-1:0], exp_v[8], exp_v[9]);
      end
    end
  endtask

  task automatic test_single_channel();
    assert_rst();
    repeat (2) tick();
    release_rst();
    repeat (8) begin
      tick();
      exp1_v = model(rst_n, edge_n, ref_e, 1, 1, 1);
      n_checks++;
      if ({done1, busy1, rst_out1} !== {exp1_v[9], exp1_v[8], exp1_v[0]}) begin
        n_err++;
        $display("FAIL single_ch edge=%0d got rst=%b busy=%b done=%b exp rst=%b busy=%b done=%b",
                 edge_n, rst_out1, busy1, done1, exp1_v[0], exp1_v[8], exp1_v[9]);
      end
    end
  endtask

  task automatic test_async_mid_release();
    assert_rst();
    tick();
    release_rst();
    repeat (23) tick();
    #3;
    assert_rst();
    #1;
    exp_v = model(rst_n, edge_n, ref_e, NUM_CH, HOLD, GAP);
    n_checks++;
    if ({done, busy, rst_out} !== {exp_v[9], exp_v[8], exp_v[NUM_CH-1:0]}) begin
      n_err++;
      $display("FAIL async_mid got rst=%b busy=%b done=%b exp rst=%b busy=%b done=%b",
               rst_out, busy, done, exp_v[NUM_CH-1:0], exp_v[8], exp_v[9]);
    end
    repeat (3) tick();
    release_rst();
    repeat (35) begin
      tick();
      exp_v = model(rst_n, edge_n, ref_e, NUM_CH, HOLD, GAP);
      n_checks++;
      if ({done, busy, rst_out} !== {exp_v[9], exp_v[8], exp_v[NUM_CH-1:0]}) begin
        n_err++;
        $display("FAIL async_restart edge=%0d got rst=%b busy=%b done=%b exp rst=%b busy=%b done=%b",
                 edge_n, rst_out, busy, done, exp_v[NUM_CH-1:0], exp_v[8], exp_v[9]);
      end
    end
  endtask

  task automatic test_soft_in_run();
    assert_rst();
    tick();
    release_rst();
    repeat (39) tick();
    pulse_soft();
    repeat (33) begin
      exp_v = model(rst_n, edge_n, ref_e, NUM_CH, HOLD, GAP);
      n_checks++;
      if ({done, busy, rst_out} !== {exp_v[9], exp_v[8], exp_v[NUM_CH-1:0]}) begin
        n_err++;
        $display("FAIL soft_run edge=%0d got rst=%b busy=%b done=%b exp rst=%b busy=%b done=%b",
                 edge_n, rst_out, busy, done, exp_v[NUM_CH-1:0], exp_v[8], exp_v[9]);
      end
      tick();
    end
  endtask

  task automatic test_soft_on_final();
    assert_rst();
    tick();
    release_rst();
    // Requests at edges 1 and 2 arrive before the synchroniser releases.
    pulse_soft();
    pulse_soft();
    repeat (27) tick();
    pulse_soft();
    repeat (36) begin
      exp_v = model(rst_n, edge_n, ref_e, NUM_CH, HOLD, GAP);
      n_checks++;
      if ({done, busy, rst_out} !== {exp_v[9], exp_v[8], exp_v[NUM_CH-1:0]}) begin
        n_err++;
        $display("FAIL soft_final edge=%0d got rst=%b busy=%b done=%b exp rst=%b busy=%b done=%b",
                 edge_n, rst_out, busy, done, exp_v[NUM_CH-1:0], exp_v[8], exp_v[9]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    int r;
    assert_rst();
    tick();
    release_rst();
    for (int c = 0; c < 800; c++) begin
      r = $urandom_range(0, 99);
      if (r < 1) begin
        #2;
        assert_rst();
        #1;
        repeat ($urandom_range(1, 3)) tick();
        release_rst();
      end else if (r < 3) begin
        pulse_soft();
      end else begin
        tick();
      end
      exp_v  = model(rst_n, edge_n, ref_e, NUM_CH, HOLD, GAP);
      exp1_v = model(rst_n, edge_n, ref_e, 1, 1, 1);
      n_checks++;
      if ({done, busy, rst_out, done1, busy1, rst_out1} !==
          {exp_v[9], exp_v[8], exp_v[NUM_CH-1:0], exp1_v[9], exp1_v[8], exp1_v[0]}) begin
        n_err++;
        $display("FAIL random edge=%0d ref=%0d got rst=%b busy=%b done=%b ch1=%b%b%b exp rst=%b busy=%b done=%b ch1=%b%b%b",
                 edge_n, ref_e, rst_out, busy, done, rst_out1, busy1, done1,
                 exp_v[NUM_CH-1:0], exp_v[8], exp_v[9], exp1_v[0], exp1_v[8], exp1_v[9]);
      end
    end
  endtask

`ifdef RESET_SEQ_ACK_EN
  task automatic test_ack();
    logic [NUM_CH-1:0] exp_rst;
    logic              exp_done;
    assert_rst();
    tick();
    ch_ready = 4'b0101;
    release_rst();
    repeat (50) begin
      tick();
      if (edge_n == 34) ch_ready[1] = 1'b1;
      if (edge_n == 44) ch_ready[3] = 1'b1;
      if (edge_n < 18)      exp_rst = 4'b1111;
      else if (edge_n < 22) exp_rst = 4'b1110;
      else if (edge_n < 35) exp_rst = 4'b1100;
      else if (edge_n < 39) exp_rst = 4'b1000;
      else                  exp_rst = 4'b0000;
      exp_done = (edge_n >= 45);
      n_checks++;
      if ({done, busy, rst_out} !== {exp_done, ~exp_done, exp_rst}) begin
        n_err++;
        $display("FAIL ack edge=%0d got rst=%b busy=%b done=%b exp rst=%b busy=%b done=%b",
                 edge_n, rst_out, busy, done, exp_rst, ~exp_done, exp_done);
      end
    end
    ch_ready = {NUM_CH{1'b1}};
  endtask
`endif

  initial begin
    test_reset();
    test_power_up();
    test_single_channel();
    test_async_mid_release();
    test_soft_in_run();
    test_soft_on_final();
    test_random();
`ifdef RESET_SEQ_ACK_EN
    test_ack();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
